// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared constants, bank FSM encoding and helpers for the banked SPRAM controller
package spram_pkg;

    localparam int SPRAM_WORDS = 16384;
    localparam int SPRAM_AW    = 14;
    localparam int BANK_DW     = 32;

    typedef enum logic [1:0] {
        BANK_ACTIVE  = 2'd0,
        BANK_WAKE    = 2'd1,
        BANK_STANDBY = 2'd2
    } bank_state_e;

    // Number of address bits needed to pick one of num_banks banks (0 for a single bank)
    function automatic int bank_sel_w(input int num_banks);
        int w;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < num_banks) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// rtl/SB_SPRAM256KA.sv - behavioural model of the iCE40UP5K 16K x 16 SPRAM primitive
module SB_SPRAM256KA
    import spram_pkg::*;
(
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] mem [SPRAM_WORDS];
    logic [15:0] dout_q;

    // Nibble-masked write or registered read; the array only responds when selected and powered
    always_ff @(posedge CLOCK) begin
        if (CHIPSELECT && !STANDBY && !SLEEP && POWEROFF) begin
            if (WREN) begin
                for (int n = 0; n < 4; n++) begin
                    if (MASKWREN[n]) begin
                        mem[ADDRESS][4*n +: 4] <= DATAIN[4*n +: 4];
                    end
                end
            end else begin
                dout_q <= mem[ADDRESS];
            end
        end
    end

    assign DATAOUT = dout_q;

endmodule

// File: rtl/spram_bank.sv
// rtl/spram_bank.sv - one 16K x 32 bank (two SPRAM cells) with idle-standby FSM under SPRAM_STANDBY_EN
module spram_bank
    import spram_pkg::*;
#(
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                touch,
    input  logic [3:0]          wen,
    input  logic [SPRAM_AW-1:0] addr,
    input  logic [BANK_DW-1:0]  wdata,
    output logic [BANK_DW-1:0]  rdata,
    output logic                active,
    output logic                standby
);

    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 65535) begin : g_bad_idle
        $fatal(1, "spram_bank: IDLE_CYCLES must be in 1..65535");
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15) begin : g_bad_wake
        $fatal(1, "spram_bank: WAKE_CYCLES must be in 1..15");
    end

    logic we;
    assign we = |wen;

`ifdef SPRAM_STANDBY_EN
    localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);
    localparam logic [3:0]  WAKE_LAST = 4'(WAKE_CYCLES - 1);

    bank_state_e state_q, state_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]  wake_cnt_q, wake_cnt_d;

    // Next-state: an access always beats the idle threshold; any request to a sleeping bank starts its wake-up
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            BANK_ACTIVE: begin
                if (cs) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = BANK_STANDBY;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            BANK_STANDBY: begin
                if (touch) begin
                    state_d    = BANK_WAKE;
                    wake_cnt_d = '0;
                end
            end
            BANK_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = BANK_ACTIVE;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = BANK_ACTIVE;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Bank FSM state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BANK_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign active  = (state_q == BANK_ACTIVE);
    assign standby = (state_q == BANK_STANDBY);
`else
    logic unused_touch;
    assign unused_touch = touch;
    assign active       = 1'b1;
    assign standby      = 1'b0;
`endif

    SB_SPRAM256KA u_cell_lo (
        .ADDRESS    (addr),
        .DATAIN     (wdata[15:0]),
        .MASKWREN   ({wen[1], wen[1], wen[0], wen[0]}),
        .WREN       (we),
        .CHIPSELECT (cs),
        .CLOCK      (clk),
        .STANDBY    (standby),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (rdata[15:0])
    );

    SB_SPRAM256KA u_cell_hi (
        .ADDRESS    (addr),
        .DATAIN     (wdata[31:16]),
        .MASKWREN   ({wen[3], wen[3], wen[2], wen[2]}),
        .WREN       (we),
        .CHIPSELECT (cs),
        .CLOCK      (clk),
        .STANDBY    (standby),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (rdata[31:16])
    );

endmodule

// File: rtl/spram_banked_ctrl.sv
// rtl/spram_banked_ctrl.sv - banked UP5K SPRAM main-RAM controller; SPRAM_STANDBY_EN enables per-bank idle standby
module spram_banked_ctrl
    import spram_pkg::*;
#(
    parameter int NUM_BANKS   = 2,
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [3:0]                                req_wen,
    input  logic [SPRAM_AW+bank_sel_w(NUM_BANKS)-1:0] req_addr,
    input  logic [BANK_DW-1:0]                        req_wdata,
    output logic                                      rsp_valid,
    output logic [BANK_DW-1:0]                        rsp_rdata,
    output logic [NUM_BANKS-1:0]                      bank_standby
);

    localparam int SEL_W  = bank_sel_w(NUM_BANKS);
    localparam int ADDR_W = SPRAM_AW + SEL_W;
    localparam int IDX_W  = (SEL_W > 0) ? SEL_W : 1;

    if (NUM_BANKS != 1 && NUM_BANKS != 2 && NUM_BANKS != 4) begin : g_bad_num_banks
        $fatal(1, "spram_banked_ctrl: NUM_BANKS must be 1, 2 or 4");
    end

    logic [IDX_W-1:0]   bank_sel;
    logic [NUM_BANKS-1:0] bank_cs;
    logic [NUM_BANKS-1:0] bank_touch;
    logic [NUM_BANKS-1:0] bank_active;
    logic [BANK_DW-1:0] bank_dout [NUM_BANKS];

    logic               ready_en_q, ready_en_d;
    logic               rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]   rd_bank_q, rd_bank_d;
    logic [BANK_DW-1:0] rdata_hold_q, rdata_hold_d;
    logic [BANK_DW-1:0] rd_mux;
    logic               accept;
    logic               is_read;

    if (SEL_W > 0) begin : g_sel
        assign bank_sel = req_addr[ADDR_W-1 -: SEL_W];
    end else begin : g_sel_one
        assign bank_sel = 1'b0;
    end

    // Ready follows the addressed bank's power state; held low in reset and until the first edge after it
    assign req_ready = ready_en_q && !rst && bank_active[bank_sel];
    assign accept    = req_valid && req_ready;
    assign is_read   = (req_wen == 4'b0000);

    // Per-bank select: touch wakes a sleeping bank, cs only fires on an accepted request
    always_comb begin
        bank_touch = '0;
        bank_cs    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_touch[b] = req_valid && (bank_sel == IDX_W'(b));
            bank_cs[b]    = bank_touch[b] && req_ready;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        spram_bank #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .cs      (bank_cs[b]),
            .touch   (bank_touch[b]),
            .wen     (req_wen),
            .addr    (req_addr[SPRAM_AW-1:0]),
            .wdata   (req_wdata),
            .rdata   (bank_dout[b]),
            .active  (bank_active[b]),
            .standby (bank_standby[b])
        );
    end

    assign rd_mux = bank_dout[rd_bank_q];

    // Response tracking: remember which bank owns the in-flight read and keep the last read data stable
    always_comb begin
        ready_en_d   = 1'b1;
        rd_pend_d    = accept && is_read;
        rd_bank_d    = (accept && is_read) ? bank_sel : rd_bank_q;
        rdata_hold_d = rd_pend_q ? rd_mux : rdata_hold_q;
    end

    // Response-path registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_bank_q    <= '0;
            rdata_hold_q <= '0;
        end else begin
            ready_en_q   <= ready_en_d;
            rd_pend_q    <= rd_pend_d;
            rd_bank_q    <= rd_bank_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign rsp_valid = rd_pend_q;
    assign rsp_rdata = rd_pend_q ? rd_mux : rdata_hold_q;

endmodule

// File: tb/tb_spram_banked_ctrl.sv
// tb/tb_spram_banked_ctrl.sv - directed self-checking bench for spram_banked_ctrl (4 banks)
module tb_spram_banked_ctrl;

    localparam int NB     = 4;
    localparam int ADDR_W = 16;
    localparam int IDLE   = 8;
    localparam int WAKE   = 2;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [NB-1:0]     bank_standby;

    int checks   = 0;
    int failures = 0;

    spram_banked_ctrl #(
        .NUM_BANKS   (NB),
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .bank_standby (bank_standby)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at edge+1, wait (bounded) for ready, let it be accepted, return at next edge+1
    task automatic issue(input logic [3:0] wen, input logic [15:0] addr, input logic [31:0] wdata,
                         output int waited);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        waited    = 0;
        #1;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("issue_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ilv_data [4];
    int w;
    int bad;

    initial begin
        ilv_data[0] = 32'h11111111;
        ilv_data[1] = 32'h22222222;
        ilv_data[2] = 32'h33333333;
        ilv_data[3] = 32'h44444444;

        rst = 1'b1; req_valid = 1'b0; req_wen = 4'h0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_standby", 32'(bank_standby), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_before_first_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_first_edge", 32'(req_ready), 32'd1);

        // Interleave: one write per bank, then back-to-back reads with no ready gaps
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_wen = 4'hF;
            req_addr = 16'(i) << 14; req_wdata = ilv_data[i];
            #1;
            chk("ilv_wr_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                chk("ilv_no_wr_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                chk("ilv_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("ilv_rsp_rdata", rsp_rdata, ilv_data[i-1]);
            end
            if (i < 4) begin
                req_valid = 1'b1; req_wen = 4'h0; req_addr = 16'(i) << 14;
                #1;
                chk("ilv_rd_ready", 32'(req_ready), 32'd1);
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rsp_drops", 32'(rsp_valid), 32'd0);
        chk("rsp_holds", rsp_rdata, 32'h44444444);

        // Byte masks on bank 0
        issue(4'hF, 16'h0010, 32'hDEADBEEF, w);
        issue(4'b0100, 16'h0010, 32'h00AA0000, w);
        chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
        issue(4'h0, 16'h0010, 32'h0, w);
        chk("mask_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mask_byte2", rsp_rdata, 32'hDEAABEEF);
        issue(4'b0010, 16'h0010, 32'h00005500, w);
        issue(4'h0, 16'h0010, 32'h0, w);
        chk("mask_byte1", rsp_rdata, 32'hDEAA55EF);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mask_hold_valid", 32'(rsp_valid), 32'd0);
        chk("mask_hold_data", rsp_rdata, 32'hDEAA55EF);

        // Outer byte lanes on bank 2
        issue(4'hF, 16'h8011, 32'h00000000, w);
        issue(4'b1001, 16'h8011, 32'hA1B2C3D4, w);
        issue(4'h0, 16'h8011, 32'h0, w);
        chk("mask_bytes30", rsp_rdata, 32'hA10000D4);

        // Write then read of the same word on consecutive cycles
        issue(4'hF, 16'h0020, 32'h12345678, w);
        issue(4'h0, 16'h0020, 32'h0, w);
        chk("wr_rd_same_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rd_same_data", rsp_rdata, 32'h12345678);

        // Reset during the response cycle of a read
        issue(4'h0, 16'h8011, 32'h0, w);
        chk("inflight_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_standby", 32'(bank_standby), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_addr = 16'h0010;
        #1;
        chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ready_after_edge", 32'(req_ready), 32'd1);
        chk("rel_no_late_rsp", 32'(rsp_valid), 32'd0);

`ifdef SPRAM_STANDBY_EN
        // Every idle counter is at IDLE-1 after this; access bank 0 exactly on that cycle
        repeat (6) @(posedge clk);
        #1;
        chk("pre_thresh_standby", 32'(bank_standby), 32'd0);
        issue(4'h0, 16'h0010, 32'h0, w);
        chk("thresh_wait", 32'(w), 32'd0);
        chk("thresh_standby", 32'(bank_standby), 32'b1110);
        chk("thresh_rdata", rsp_rdata, 32'hDEAA55EF);
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("bank0_cleared", 32'(bank_standby[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("bank0_sleeps", 32'(bank_standby[0]), 32'd1);
        chk("bank1_asleep", 32'(bank_standby[1]), 32'd1);

        // Wake bank 1: the standby cycle plus WAKE cycles of stall, then the data is intact
        issue(4'h0, 16'h4000, 32'h0, w);
        chk("wake_stall", 32'(w), 32'(1 + WAKE));
        chk("wake_standby", 32'(bank_standby[1]), 32'd0);
        chk("wake_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wake_rdata", rsp_rdata, 32'h22222222);
        req_valid = 1'b0;
`else
        // Contents survive reset
        issue(4'h0, 16'h0010, 32'h0, w);
        chk("post_rst_rdata0", rsp_rdata, 32'hDEAA55EF);
        issue(4'h0, 16'h8011, 32'h0, w);
        chk("post_rst_rdata2", rsp_rdata, 32'hA10000D4);
        req_valid = 1'b0;

        // Banks never sleep without the standby feature
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            req_addr = 16'(k % 4) << 14;
            #1;
            if (bank_standby !== '0 || req_ready !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        chk("idle200_bad_cycles", 32'(bad), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
